// File: rtl/spi_pkg.sv
// Shared SPI scheduler types and default timing constants (also used by spi_root).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    BLANK
  } sched_state_t;

  localparam int SPI_DW         = 16;
  localparam int SPI_SCLK_CLKS  = 6;
  localparam int SPI_BLANK_SCLK = 3;

endpackage

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o
);

  logic found;
  int   idx;

  // NOTE: every output and temporary gets a default first, so no path leaves a latch.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Schedules DW-bit SPI frames from N_REQ requesters onto one frame engine.
// Optional macro SPI_SCHED_TRG_PRIO_EN: requester 0 (trigger) preempts round-robin.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DW          = SPI_DW,
  parameter int SCLK_CLKS   = SPI_SCLK_CLKS,
  parameter int BLANK_SCLK  = SPI_BLANK_SCLK,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                xfer_start,
  output logic [DW-1:0]       xfer_wdata,
  input  logic                xfer_busy,
  input  logic                xfer_done,
  input  logic [DW-1:0]       xfer_rdata,
  output logic                rsp_valid,
  output logic [IW-1:0]       rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                sched_idle
);

  localparam int BLANK_CYC = BLANK_SCLK * SCLK_CLKS;
  localparam int CW        = $clog2(TIMEOUT_CYC + 1);

  sched_state_t     state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    blank_len_q, blank_len_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] arb_gnt, win_oh;
  logic [IW-1:0]    arb_id, win_id;
  logic             win_adv, arb_go, timeout_hit;
  logic [CW-1:0]    blank_entry_len;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

`ifdef SPI_SCHED_TRG_PRIO_EN
  // Trigger grants leave the round-robin pointer where it was.
  assign win_oh          = req_valid[0] ? N_REQ'(1) : arb_gnt;
  assign win_id          = req_valid[0] ? '0 : arb_id;
  assign win_adv         = !req_valid[0];
  assign blank_entry_len = req_valid[0] ? CW'(SCLK_CLKS) : CW'(BLANK_CYC);
`else
  assign win_oh          = arb_gnt;
  assign win_id          = arb_id;
  assign win_adv         = 1'b1;
  assign blank_entry_len = CW'(BLANK_CYC);
`endif

  assign arb_go      = (|req_valid) && !xfer_busy;
  // cnt_q counts cycles since the START cycle, so this fires TIMEOUT_CYC-1 cycles in.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // NOTE: sequential state uses non-blocking assignments only; all next values come from _d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      blank_len_q <= CW'(BLANK_CYC);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      blank_len_q <= blank_len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    blank_len_d = blank_len_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_go) begin
          wdata_d  = req_data[win_id*DW +: DW];
          cur_id_d = win_id;
          if (win_adv) begin
            rr_ptr_d = (win_id == IW'(N_REQ - 1)) ? '0 : win_id + IW'(1);
          end
          state_d = START;
        end
      end
      START: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Done takes precedence when it lands on the timeout cycle.
        if (xfer_done || timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_data_d  = xfer_done ? xfer_rdata : '0;
          rsp_err_d   = !xfer_done;
          cnt_d       = '0;
          blank_len_d = blank_entry_len;
          state_d     = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == blank_len_q - CW'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE && arb_go) ? win_oh : '0;
    xfer_start = (state_q == START);
    sched_idle = (state_q == IDLE);
  end

  assign xfer_wdata = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule
